// File: rtl/la_readout_ctrl.sv
// Capture/dump sequencer for the RedTin logic analyzer: re-arms the analyzer, waits for done,
// then streams a header byte followed by every buffer word (MSB byte first) over valid/ready.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for arm
// WAIT_DONE | analyzer re-armed, waiting for la_done (first cycle ignored)
// HEADER    | presenting HEADER_BYTE
// RD_WAIT   | waiting READ_LATENCY+1 clocks for la_read_data to settle
// SEND      | presenting the bytes of the latched word
// FINISH    | pulsing la_reset and dump_done, then back to IDLE
module la_readout_ctrl #(
    parameter int          DATA_WIDTH   = 128,
    parameter int          DEPTH        = 512,
    parameter int          ADDR_WIDTH   = 9,
    parameter int          READ_LATENCY = 2,
    parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  la_done,
    input  logic [DATA_WIDTH-1:0] la_read_data,
    output logic                  la_reset,
    output logic [ADDR_WIDTH-1:0] la_read_addr,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  dump_done
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_DONE, S_HEADER, S_RD_WAIT, S_SEND, S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic                  first_q, first_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  la_reset_q, la_reset_d;
    logic                  dump_done_q, dump_done_d;
    logic [DATA_WIDTH-1:0] word_shift;
    logic                  xfer;

    assign tx_valid     = (state_q == S_HEADER) || (state_q == S_SEND);
    assign xfer         = tx_valid && tx_ready;
    assign busy         = (state_q != S_IDLE);
    assign la_reset     = la_reset_q;
    assign dump_done    = dump_done_q;
    assign la_read_addr = addr_q;
    assign word_shift   = word_q << {idx_q, 3'b000};

    always_comb begin
        tx_data = '0;
        if (state_q == S_HEADER)
            tx_data = HEADER_BYTE;
        else if (state_q == S_SEND)
            tx_data = word_shift[DATA_WIDTH-1 -: 8];
    end

    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        word_d      = word_q;
        addr_d      = addr_q;
        la_reset_d  = 1'b0;
        dump_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arm && !abort) begin
                    state_d    = S_WAIT_DONE;
                    first_d    = 1'b1;
                    la_reset_d = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                // a done left over from before the re-arm is still visible on the first cycle
                first_d = 1'b0;
                if (la_done && !first_q) begin
                    addr_d  = '0;
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                if (xfer) begin
                    cnt_d   = 3'(READ_LATENCY);
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == 3'd0) begin
                    word_d  = la_read_data;
                    idx_d   = '0;
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (idx_q != IDX_W'(NB - 1)) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_d     = S_FINISH;
                        la_reset_d  = 1'b1;
                        dump_done_d = 1'b1;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        cnt_d   = 3'(READ_LATENCY);
                        state_d = S_RD_WAIT;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            la_reset_d  = 1'b1;
            dump_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            first_q     <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            addr_q      <= '0;
            la_reset_q  <= 1'b0;
            dump_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            la_reset_q  <= la_reset_d;
            dump_done_q <= dump_done_d;
        end
    end

endmodule

// File: doc/la_readout_ctrl.md
Name: la_readout_ctrl

Overview:
- Sequences one RedTin capture/dump cycle: re-arms the analyzer, waits for capture done, walks all buffer offsets, and streams each captured word out as bytes over a valid/ready byte interface (toward the UART/host link).
- Sits between the logic analyzer core (read_addr/read_data/done/reset) and the host byte transport.

Parameters:
- DATA_WIDTH, 128, analyzer sample width; must be a multiple of 8.
- DEPTH, 512, number of buffer entries to dump.
- ADDR_WIDTH, 9, width of la_read_addr; must satisfy 2^ADDR_WIDTH >= DEPTH.
- READ_LATENCY, 2, clocks from la_read_addr change to valid la_read_data; range 1..7.
- HEADER_BYTE, 8'hA5, frame start byte sent before the first data byte.

Ports:
- clk  input  1  capture/system clock
- reset_n  input  1  asynchronous active-low reset
- arm  input  1  single-cycle request to start a capture+dump cycle
- abort  input  1  single-cycle request to cancel the current cycle
- la_done  input  1  analyzer done flag
- la_read_data  input  DATA_WIDTH  analyzer read data
- la_reset  output  1  one-cycle re-arm pulse to the analyzer
- la_read_addr  output  ADDR_WIDTH  buffer offset to read
- tx_data  output  8  outgoing byte
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  sink accepts a byte
- busy  output  1  high in any state other than IDLE
- dump_done  output  1  one-cycle pulse when a dump completes

Behaviour:
- Async reset (reset_n low): state IDLE. All outputs 0 (la_reset, la_read_addr, tx_data, tx_valid, busy, dump_done). Word latch, byte index, and wait counter are cleared.
- Transfer rule: a byte transfers on a clock edge where tx_valid=1 and tx_ready=1. Once tx_valid is raised, tx_data is held stable and tx_valid stays high until the transfer, except on abort.
- States:
  - IDLE: on arm=1, pulse la_reset for 1 cycle, go to WAIT_DONE.
  - WAIT_DONE: ignores la_done on the first cycle after entry, so a stale done from before the re-arm is not seen. Afterwards, on la_done=1: la_read_addr=0, go to HEADER.
  - HEADER: tx_data=HEADER_BYTE, tx_valid=1. On transfer, go to RD_WAIT with wait counter=READ_LATENCY.
  - RD_WAIT: decrement the counter each clock. When it reaches 0, latch la_read_data into the word register, set byte index=0, go to SEND.
  - SEND: tx_data=word[DATA_WIDTH-1-8*idx -: 8] (MSB byte first), tx_valid=1. On transfer with idx<DATA_WIDTH/8-1, increment idx. On transfer of the last byte:
    - if la_read_addr==DEPTH-1, go to FINISH;
    - else increment la_read_addr and go to RD_WAIT with counter=READ_LATENCY.
  - FINISH: 1-cycle la_reset pulse and 1-cycle dump_done pulse (same cycle), go to IDLE.
- Frame size: 1 header byte + DEPTH*DATA_WIDTH/8 data bytes (8193 for the defaults). Words are sent in offset order 0..DEPTH-1.
- la_read_addr changes only on the last-byte transfer and on the WAIT_DONE exit, so it is stable throughout each RD_WAIT. It never exceeds DEPTH-1 and holds its last value until the next dump.
- tx_valid is low in IDLE, WAIT_DONE, RD_WAIT and FINISH. Minimum gap between words is READ_LATENCY+1 clocks.
- Simultaneous events:
  - arm outside IDLE: ignored.
  - abort has priority over every transition: next state IDLE, tx_valid dropped in the same edge (a pending byte is discarded), la_reset pulsed 1 cycle, dump_done not pulsed.
  - abort in IDLE: no effect.
  - arm and abort together in IDLE: abort wins, no action.
- tx_ready stuck low: the block holds in HEADER/SEND indefinitely with no timeout.
- reset_n asserted mid-dump: immediate return to reset values. The analyzer is not re-armed until the next arm.

Test Plan:
- Basic dump: arm, la_done=1 after 20 clocks, tx_ready=1, model data word(n)={16{n[7:0]}}.
  - First byte is 8'hA5, followed by 8192 data bytes (word n contributes 16 bytes equal to n[7:0]).
  - Exactly one dump_done pulse, together with one la_reset pulse; busy falls on the next cycle.
- Byte order: word 0 = 128'h00112233_44556677_8899AABB_CCDDEEFF -> bytes after the header are 00, 11, ..., FF in that order.
- Backpressure: tx_ready random 30% duty -> tx_data/tx_valid stable while stalled, no byte lost or duplicated, total count still 8193.
- Stale done: la_done held 1 before arm -> la_reset pulses, then no HEADER byte until la_done has been sampled high on the second WAIT_DONE cycle or later.
- Abort mid-frame: abort while sending word 37 byte 5 with tx_valid=1 -> next cycle tx_valid=0, busy=0, la_reset pulsed, no dump_done. A following arm restarts from the header and offset 0.
- Async reset mid-RD_WAIT and arm/abort during WAIT_DONE:
  - reset_n low -> all outputs 0 without a clock edge.
  - arm pulses while busy -> ignored (no extra la_reset).
